// File: rtl/rat_pkg.sv
// Shared widths and types for the register alias table and its checkpoint ring.
package rat_pkg;

    localparam int DEF_RENAME_WIDTH = 4;
    localparam int DEF_ARCH_REGS    = 32;
    localparam int DEF_PREG_NUM     = 128;
    localparam int DEF_CKPT_NUM     = 4;

    localparam int PREG_W     = $clog2(DEF_PREG_NUM);
    localparam int ARCH_IDX_W = 5;
    localparam int CKPT_ID_W  = $clog2(DEF_CKPT_NUM);

    typedef logic [PREG_W-1:0]     preg_t;
    typedef logic [ARCH_IDX_W-1:0] arch_idx_t;
    typedef logic [CKPT_ID_W-1:0]  ckpt_id_t;
    typedef preg_t [DEF_ARCH_REGS-1:0] rat_map_t;

endpackage

// File: rtl/rat_ckpt_if.sv
// Rename-group bundle between decode/branch logic (master) and the alias table (slave).
interface rat_ckpt_if
    import rat_pkg::*;
#(
    parameter int RENAME_WIDTH = DEF_RENAME_WIDTH,
    parameter int ARCH_REGS    = DEF_ARCH_REGS,
    parameter int PREG_NUM     = DEF_PREG_NUM,
    parameter int CKPT_NUM     = DEF_CKPT_NUM
);
    localparam int PW = $clog2(PREG_NUM);
    localparam int CW = $clog2(CKPT_NUM);

    logic                                    rename_valid;
    logic                                    rename_ready;
    logic [RENAME_WIDTH-1:0][ARCH_IDX_W-1:0] rd_idx;
    logic [RENAME_WIDTH-1:0][ARCH_IDX_W-1:0] rj_idx;
    logic [RENAME_WIDTH-1:0][ARCH_IDX_W-1:0] rk_idx;
    logic [RENAME_WIDTH-1:0]                 rd_en;
    logic [RENAME_WIDTH-1:0]                 rj_en;
    logic [RENAME_WIDTH-1:0]                 rk_en;
    logic [RENAME_WIDTH-1:0][PW-1:0]         new_preg;
    logic [RENAME_WIDTH-1:0]                 ckpt_req;
    logic [CW-1:0]                           ckpt_id;
    logic [RENAME_WIDTH-1:0][PW-1:0]         rj_preg;
    logic [RENAME_WIDTH-1:0][PW-1:0]         rk_preg;
    logic [RENAME_WIDTH-1:0][PW-1:0]         rd_old_preg;
    logic                                    ckpt_release;
    logic                                    ckpt_restore_valid;
    logic [CW-1:0]                           ckpt_restore_id;
    logic                                    recover_valid;
    logic [ARCH_REGS-1:0][PW-1:0]            recover_map;

    modport master (
        output rename_valid, rd_idx, rj_idx, rk_idx, rd_en, rj_en, rk_en,
               new_preg, ckpt_req, ckpt_release, ckpt_restore_valid,
               ckpt_restore_id, recover_valid, recover_map,
        input  rename_ready, ckpt_id, rj_preg, rk_preg, rd_old_preg
    );

    modport slave (
        input  rename_valid, rd_idx, rj_idx, rk_idx, rd_en, rj_en, rk_en,
               new_preg, ckpt_req, ckpt_release, ckpt_restore_valid,
               ckpt_restore_id, recover_valid, recover_map,
        output rename_ready, ckpt_id, rj_preg, rk_preg, rd_old_preg
    );

endinterface

// File: rtl/rat_ckpt_ring.sv
// Ring of map snapshots with head/tail/count bookkeeping for branch checkpoints.
module rat_ckpt_ring
    import rat_pkg::*;
#(
    parameter int CKPT_NUM = DEF_CKPT_NUM,
    parameter int MAP_W    = DEF_ARCH_REGS * PREG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [MAP_W-1:0]            push_map,
    input  logic                        release_en,
    input  logic                        restore_valid,
    input  logic [$clog2(CKPT_NUM)-1:0] restore_id,
    input  logic                        recover,
    output logic [$clog2(CKPT_NUM)-1:0] head,
    output logic                        full,
    output logic [MAP_W-1:0]            restore_map
);
    localparam int CW = $clog2(CKPT_NUM);
    localparam int NW = CW + 1;

    logic [MAP_W-1:0] slot_mem [CKPT_NUM];

    logic [CW-1:0] head_reg, head_next;
    logic [CW-1:0] tail_reg, tail_next;
    logic [NW-1:0] count_reg, count_next;

    logic          rel_ok;
    logic [CW-1:0] tail_adv;
    logic [NW-1:0] count_rel;
    logic [CW-1:0] restore_diff;
    logic [CW-1:0] restore_offs;

    // Snapshot storage carries no reset; only slots in [tail, head) are ever read back.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_mem[head_reg] <= push_map;
        end
    end

    assign restore_map = slot_mem[restore_id];

    // A release is folded in before any restore so the restore sees the advanced tail.
    assign rel_ok       = release_en && (count_reg != '0);
    assign tail_adv     = tail_reg + CW'(rel_ok);
    assign count_rel    = count_reg - NW'(rel_ok);
    assign restore_diff = restore_id + CW'(1) - tail_adv;
    assign restore_offs = restore_id - tail_reg;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (recover) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else if (restore_valid) begin
            tail_next  = tail_adv;
            head_next  = restore_id + CW'(1);
            // A zero modular distance with live entries means the youngest of a full ring.
            if (restore_diff == '0 && count_rel != '0) begin
                count_next = NW'(CKPT_NUM);
            end else begin
                count_next = {1'b0, restore_diff};
            end
        end else begin
            head_next  = head_reg + CW'(push);
            tail_next  = tail_adv;
            count_next = count_rel + NW'(push);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign head = head_reg;
    assign full = (count_reg == NW'(CKPT_NUM));

    restore_id_live: assert property (@(posedge clk) disable iff (rst)
        (restore_valid && !recover) |-> ({1'b0, restore_offs} < count_reg));

    release_restore_clash: assert property (@(posedge clk) disable iff (rst)
        (restore_valid && !recover && release_en) |-> (restore_id != tail_reg));

endmodule

// File: rtl/rat_ckpt.sv
// N-wide register alias table with intra-group bypass and checkpoint restore.
// Optional RAT_PERF_CNT_EN adds saturating stall/restore performance counters.
module rat_ckpt
    import rat_pkg::*;
#(
    parameter int RENAME_WIDTH = DEF_RENAME_WIDTH,
    parameter int ARCH_REGS    = DEF_ARCH_REGS,
    parameter int PREG_NUM     = DEF_PREG_NUM,
    parameter int CKPT_NUM     = DEF_CKPT_NUM
) (
    input  logic        clk,
    input  logic        rst,
    rat_ckpt_if.slave   rif
`ifdef RAT_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_restore_cnt
`endif
);
    localparam int PW = $clog2(PREG_NUM);
    localparam int CW = $clog2(CKPT_NUM);

    typedef logic [ARCH_REGS-1:0][PW-1:0] map_t;

    map_t          map_reg;
    map_t          map_next;
    map_t          rename_map;
    map_t          ckpt_snap;
    map_t          restore_map;
    logic [CW-1:0] ring_head;
    logic          ring_full;
    logic          do_restore;
    logic          accept;
    logic          push;

    // Youngest older slot writing the same non-zero register supplies the mapping.
    function automatic logic [PW-1:0] src_map(
        input logic [ARCH_IDX_W-1:0]                 src,
        input int                                    slot,
        input map_t                                  m,
        input logic [RENAME_WIDTH-1:0]               en,
        input logic [RENAME_WIDTH-1:0][ARCH_IDX_W-1:0] idx,
        input logic [RENAME_WIDTH-1:0][PW-1:0]       np
    );
        logic [PW-1:0] v;
        v = m[src];
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            if (j < slot && en[j] && idx[j] == src) begin
                v = np[j];
            end
        end
        if (src == '0) begin
            v = '0;
        end
        return v;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < RENAME_WIDTH; gi++) begin : g_read
            assign rif.rj_preg[gi] = rif.rj_en[gi]
                ? src_map(rif.rj_idx[gi], gi, map_reg, rif.rd_en, rif.rd_idx, rif.new_preg) : '0;
            assign rif.rk_preg[gi] = rif.rk_en[gi]
                ? src_map(rif.rk_idx[gi], gi, map_reg, rif.rd_en, rif.rd_idx, rif.new_preg) : '0;
            assign rif.rd_old_preg[gi] = rif.rd_en[gi]
                ? src_map(rif.rd_idx[gi], gi, map_reg, rif.rd_en, rif.rd_idx, rif.new_preg) : '0;
        end
    endgenerate

    // Slots applied in order so the highest colliding slot wins; snapshot taken after slot k.
    always_comb begin
        rename_map = map_reg;
        ckpt_snap  = map_reg;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (rif.rd_en[k] && rif.rd_idx[k] != '0) begin
                rename_map[rif.rd_idx[k]] = rif.new_preg[k];
            end
            if (rif.ckpt_req[k]) begin
                ckpt_snap = rename_map;
            end
        end
    end

    assign rif.rename_ready = !ring_full;
    assign rif.ckpt_id      = ring_head;
    assign do_restore       = rif.ckpt_restore_valid && !rif.recover_valid;
    assign accept           = rif.rename_valid && rif.rename_ready
                              && !rif.recover_valid && !rif.ckpt_restore_valid;
    assign push             = accept && (rif.ckpt_req != '0);

    rat_ckpt_ring #(
        .CKPT_NUM (CKPT_NUM),
        .MAP_W    (ARCH_REGS * PW)
    ) u_ring (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_map      (ckpt_snap),
        .release_en    (rif.ckpt_release),
        .restore_valid (do_restore),
        .restore_id    (rif.ckpt_restore_id),
        .recover       (rif.recover_valid),
        .head          (ring_head),
        .full          (ring_full),
        .restore_map   (restore_map)
    );

    always_comb begin
        map_next = map_reg;
        if (rif.recover_valid) begin
            map_next = rif.recover_map;
        end else if (do_restore) begin
            map_next = restore_map;
        end else if (accept) begin
            map_next = rename_map;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_reg[i] <= PW'(i);
            end
        end else begin
            map_reg <= map_next;
        end
    end

`ifdef RAT_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt   <= '0;
            perf_restore_cnt <= '0;
        end else begin
            if (rif.rename_valid && !rif.rename_ready && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if ((rif.recover_valid || rif.ckpt_restore_valid) && perf_restore_cnt != '1) begin
                perf_restore_cnt <= perf_restore_cnt + 32'd1;
            end
        end
    end
`endif

    single_ckpt_req: assert property (@(posedge clk) disable iff (rst)
        rif.rename_valid |-> $onehot0(rif.ckpt_req));

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed bench for rat_ckpt: bypass, r0 handling, checkpoint wrap, restore and recover.
module tb_rat_ckpt;
    import rat_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rat_ckpt_if rif ();

`ifdef RAT_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_restore_cnt;
`endif

    rat_ckpt dut (
        .clk (clk),
        .rst (rst),
        .rif (rif)
`ifdef RAT_PERF_CNT_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_restore_cnt (perf_restore_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        rif.rename_valid       = 1'b0;
        rif.rd_idx             = '0;
        rif.rj_idx             = '0;
        rif.rk_idx             = '0;
        rif.rd_en              = '0;
        rif.rj_en              = '0;
        rif.rk_en              = '0;
        rif.new_preg           = '0;
        rif.ckpt_req           = '0;
        rif.ckpt_release       = 1'b0;
        rif.ckpt_restore_valid = 1'b0;
        rif.ckpt_restore_id    = '0;
        rif.recover_valid      = 1'b0;
        rif.recover_map        = '0;
    endtask

    task automatic tick(input string what);
        @(posedge clk);
        #1;
        $display("txn %s", what);
    endtask

    task automatic read_map(input logic [4:0] r, output logic [PREG_W-1:0] v);
        rif.rj_en[0]  = 1'b1;
        rif.rj_idx[0] = r;
        #1;
        v = rif.rj_preg[0];
        rif.rj_en[0]  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [PREG_W-1:0] v;
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("txn reset released");
        read_map(5'd5, v);
        total++; if (v !== 7'd5) begin bad++; $display("FAIL reset_map5 got=%0d exp=5", v); end
        total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", rif.rename_ready); end
        total++; if (rif.ckpt_id !== 2'd0) begin bad++; $display("FAIL reset_ckpt_id got=%0d exp=0", rif.ckpt_id); end
        rif.rj_idx[1] = 5'd5;
        #1;
        total++; if (rif.rj_preg[1] !== 7'd0) begin bad++; $display("FAIL reset_rj_disabled got=%0d exp=0", rif.rj_preg[1]); end
        idle();
    endtask

    task automatic test_bypass();
        logic [PREG_W-1:0] v;
        idle();
        rif.rename_valid = 1'b1;
        rif.rd_en[0] = 1'b1; rif.rd_idx[0] = 5'd3; rif.new_preg[0] = 7'd40;
        rif.rj_en[1] = 1'b1; rif.rj_idx[1] = 5'd3;
        rif.rd_en[1] = 1'b1; rif.rd_idx[1] = 5'd3; rif.new_preg[1] = 7'd41;
        rif.rk_en[2] = 1'b1; rif.rk_idx[2] = 5'd3;
        #1;
        total++; if (rif.rj_preg[1] !== 7'd40) begin bad++; $display("FAIL bypass_rj1 got=%0d exp=40", rif.rj_preg[1]); end
        total++; if (rif.rd_old_preg[1] !== 7'd40) begin bad++; $display("FAIL bypass_rdold1 got=%0d exp=40", rif.rd_old_preg[1]); end
        total++; if (rif.rk_preg[2] !== 7'd41) begin bad++; $display("FAIL bypass_rk2 got=%0d exp=41", rif.rk_preg[2]); end
        total++; if (rif.rd_old_preg[0] !== 7'd3) begin bad++; $display("FAIL bypass_rdold0 got=%0d exp=3", rif.rd_old_preg[0]); end
        tick("bypass group r3->40,41");
        idle();
        read_map(5'd3, v);
        total++; if (v !== 7'd41) begin bad++; $display("FAIL bypass_commit_r3 got=%0d exp=41", v); end
    endtask

    task automatic test_zero_reg();
        logic [PREG_W-1:0] v;
        idle();
        rif.rename_valid = 1'b1;
        rif.rd_en[0] = 1'b1; rif.rd_idx[0] = 5'd0; rif.new_preg[0] = 7'd50;
        rif.rj_en[1] = 1'b1; rif.rj_idx[1] = 5'd0;
        #1;
        total++; if (rif.rj_preg[1] !== 7'd0) begin bad++; $display("FAIL zero_rj1 got=%0d exp=0", rif.rj_preg[1]); end
        total++; if (rif.rd_old_preg[0] !== 7'd0) begin bad++; $display("FAIL zero_rdold0 got=%0d exp=0", rif.rd_old_preg[0]); end
        tick("r0 write group");
        idle();
        read_map(5'd0, v);
        total++; if (v !== 7'd0) begin bad++; $display("FAIL zero_map_r0 got=%0d exp=0", v); end
        read_map(5'd3, v);
        total++; if (v !== 7'd41) begin bad++; $display("FAIL zero_map_r3 got=%0d exp=41", v); end
    endtask

    task automatic test_ckpt_wrap();
        logic [PREG_W-1:0] v;
        for (int g = 0; g < 4; g++) begin
            idle();
            rif.rename_valid = 1'b1;
            rif.ckpt_req[0]  = 1'b1;
            #1;
            total++; if (rif.ckpt_id !== 2'(g)) begin bad++; $display("FAIL wrap_id%0d got=%0d exp=%0d", g, rif.ckpt_id, g); end
            total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready%0d got=%0b exp=1", g, rif.rename_ready); end
            tick("ckpt push");
        end
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b0) begin bad++; $display("FAIL wrap_full_ready got=%0b exp=0", rif.rename_ready); end
        total++; if (rif.ckpt_id !== 2'd0) begin bad++; $display("FAIL wrap_full_id got=%0d exp=0", rif.ckpt_id); end
        rif.rename_valid = 1'b1;
        rif.rd_en[0] = 1'b1; rif.rd_idx[0] = 5'd9; rif.new_preg[0] = 7'd99;
        tick("stalled group r9->99");
        idle();
        read_map(5'd9, v);
        total++; if (v !== 7'd9) begin bad++; $display("FAIL wrap_stall_r9 got=%0d exp=9", v); end
        rif.ckpt_release = 1'b1;
        tick("release oldest");
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL wrap_release_ready got=%0b exp=1", rif.rename_ready); end
        rif.rename_valid = 1'b1;
        rif.ckpt_req[0]  = 1'b1;
        #1;
        total++; if (rif.ckpt_id !== 2'd0) begin bad++; $display("FAIL wrap_reuse_id got=%0d exp=0", rif.ckpt_id); end
        tick("ckpt push after wrap");
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b0) begin bad++; $display("FAIL wrap_refull_ready got=%0b exp=0", rif.rename_ready); end
    endtask

    task automatic test_async_reset();
        logic [PREG_W-1:0] v;
        idle();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        $display("txn async reset asserted");
        total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%0b exp=1", rif.rename_ready); end
        total++; if (rif.ckpt_id !== 2'd0) begin bad++; $display("FAIL areset_id got=%0d exp=0", rif.ckpt_id); end
        read_map(5'd3, v);
        total++; if (v !== 7'd3) begin bad++; $display("FAIL areset_map_r3 got=%0d exp=3", v); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_restore();
        logic [PREG_W-1:0] v;
        idle();
        rif.rename_valid = 1'b1;
        rif.rd_en[1] = 1'b1; rif.rd_idx[1] = 5'd7; rif.new_preg[1] = 7'd60; rif.ckpt_req[1] = 1'b1;
        rif.rd_en[2] = 1'b1; rif.rd_idx[2] = 5'd7; rif.new_preg[2] = 7'd61;
        #1;
        total++; if (rif.ckpt_id !== 2'd0) begin bad++; $display("FAIL rst_ckA_id got=%0d exp=0", rif.ckpt_id); end
        total++; if (rif.rd_old_preg[2] !== 7'd60) begin bad++; $display("FAIL rst_ckA_rdold2 got=%0d exp=60", rif.rd_old_preg[2]); end
        tick("ckpt A r7->60,61");
        idle();
        rif.rename_valid = 1'b1;
        rif.rd_en[0] = 1'b1; rif.rd_idx[0] = 5'd7; rif.new_preg[0] = 7'd70; rif.ckpt_req[0] = 1'b1;
        #1;
        total++; if (rif.ckpt_id !== 2'd1) begin bad++; $display("FAIL rst_ckB_id got=%0d exp=1", rif.ckpt_id); end
        total++; if (rif.rd_old_preg[0] !== 7'd61) begin bad++; $display("FAIL rst_ckB_rdold0 got=%0d exp=61", rif.rd_old_preg[0]); end
        tick("ckpt B r7->70");
        idle();
        rif.rename_valid = 1'b1; rif.ckpt_req[0] = 1'b1;
        rif.rd_en[1] = 1'b1; rif.rd_idx[1] = 5'd7; rif.new_preg[1] = 7'd72;
        tick("ckpt C r7->72");
        idle();
        read_map(5'd7, v);
        total++; if (v !== 7'd72) begin bad++; $display("FAIL rst_pre_r7 got=%0d exp=72", v); end
        rif.ckpt_restore_valid = 1'b1; rif.ckpt_restore_id = 2'd0;
        rif.rename_valid = 1'b1;
        rif.rd_en[0] = 1'b1; rif.rd_idx[0] = 5'd7; rif.new_preg[0] = 7'd80;
        tick("restore id0 with dropped group");
        idle();
        read_map(5'd7, v);
        total++; if (v !== 7'd60) begin bad++; $display("FAIL rst_restored_r7 got=%0d exp=60", v); end
        total++; if (rif.ckpt_id !== 2'd1) begin bad++; $display("FAIL rst_head got=%0d exp=1", rif.ckpt_id); end
        for (int n = 1; n < 4; n++) begin
            idle();
            rif.rename_valid = 1'b1; rif.ckpt_req[0] = 1'b1;
            #1;
            total++; if (rif.ckpt_id !== 2'(n)) begin bad++; $display("FAIL rst_refill_id%0d got=%0d exp=%0d", n, rif.ckpt_id, n); end
            total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL rst_refill_ready%0d got=%0b exp=1", n, rif.rename_ready); end
            tick("refill push");
        end
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b0) begin bad++; $display("FAIL rst_refill_full got=%0b exp=0", rif.rename_ready); end
        rif.ckpt_release = 1'b1;
        rif.ckpt_restore_valid = 1'b1; rif.ckpt_restore_id = 2'd2;
        tick("release + restore id2");
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL relrst_ready got=%0b exp=1", rif.rename_ready); end
        total++; if (rif.ckpt_id !== 2'd3) begin bad++; $display("FAIL relrst_head got=%0d exp=3", rif.ckpt_id); end
        rif.rename_valid = 1'b1; rif.ckpt_req[0] = 1'b1;
        rif.rd_en[0] = 1'b1; rif.rd_idx[0] = 5'd7; rif.new_preg[0] = 7'd90;
        tick("ckpt id3 r7->90");
        idle();
        rif.rename_valid = 1'b1; rif.ckpt_req[0] = 1'b1;
        rif.rd_en[1] = 1'b1; rif.rd_idx[1] = 5'd7; rif.new_preg[1] = 7'd91;
        #1;
        total++; if (rif.ckpt_id !== 2'd0) begin bad++; $display("FAIL relrst_id0 got=%0d exp=0", rif.ckpt_id); end
        total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL relrst_ready2 got=%0b exp=1", rif.rename_ready); end
        tick("ckpt id0 then r7->91");
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b0) begin bad++; $display("FAIL relrst_full got=%0b exp=0", rif.rename_ready); end
        read_map(5'd7, v);
        total++; if (v !== 7'd91) begin bad++; $display("FAIL relrst_r7 got=%0d exp=91", v); end
        rif.ckpt_restore_valid = 1'b1; rif.ckpt_restore_id = 2'd0;
        tick("restore youngest id0 of full ring");
        idle();
        read_map(5'd7, v);
        total++; if (v !== 7'd90) begin bad++; $display("FAIL fullrst_r7 got=%0d exp=90", v); end
        total++; if (rif.rename_ready !== 1'b0) begin bad++; $display("FAIL fullrst_ready got=%0b exp=0", rif.rename_ready); end
        total++; if (rif.ckpt_id !== 2'd1) begin bad++; $display("FAIL fullrst_head got=%0d exp=1", rif.ckpt_id); end
    endtask

    task automatic test_recover();
        logic [PREG_W-1:0] v;
        idle();
        rif.ckpt_release = 1'b1;
        tick("release oldest");
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL rec_pre_ready got=%0b exp=1", rif.rename_ready); end
        rif.recover_valid = 1'b1;
        for (int i = 0; i < 32; i++) rif.recover_map[i] = 7'(i + 32);
        rif.ckpt_restore_valid = 1'b1; rif.ckpt_restore_id = 2'd3;
        rif.rename_valid = 1'b1; rif.ckpt_req[0] = 1'b1;
        rif.rd_en[0] = 1'b1; rif.rd_idx[0] = 5'd5; rif.new_preg[0] = 7'd100;
        tick("recover with restore and group");
        idle();
        read_map(5'd5, v);
        total++; if (v !== 7'd37) begin bad++; $display("FAIL rec_r5 got=%0d exp=37", v); end
        read_map(5'd7, v);
        total++; if (v !== 7'd39) begin bad++; $display("FAIL rec_r7 got=%0d exp=39", v); end
        read_map(5'd31, v);
        total++; if (v !== 7'd63) begin bad++; $display("FAIL rec_r31 got=%0d exp=63", v); end
        read_map(5'd0, v);
        total++; if (v !== 7'd0) begin bad++; $display("FAIL rec_r0 got=%0d exp=0", v); end
        total++; if (rif.ckpt_id !== 2'd0) begin bad++; $display("FAIL rec_head got=%0d exp=0", rif.ckpt_id); end
        rif.ckpt_release = 1'b1;
        tick("release on empty ring");
        for (int g = 0; g < 4; g++) begin
            idle();
            rif.rename_valid = 1'b1; rif.ckpt_req[0] = 1'b1;
            #1;
            total++; if (rif.ckpt_id !== 2'(g)) begin bad++; $display("FAIL rec_push_id%0d got=%0d exp=%0d", g, rif.ckpt_id, g); end
            total++; if (rif.rename_ready !== 1'b1) begin bad++; $display("FAIL rec_push_ready%0d got=%0b exp=1", g, rif.rename_ready); end
            tick("post-recover push");
        end
        idle();
        #1;
        total++; if (rif.rename_ready !== 1'b0) begin bad++; $display("FAIL rec_full got=%0b exp=0", rif.rename_ready); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_ckpt_wrap();
        test_async_reset();
        test_restore();
        test_recover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
